// File: rtl/alu_stream.sv
// alu_stream: streaming ADD/SUB/MUL/DIV unit with valid/ready on both sides.
// MUL is a fixed-latency unit and DIV is a restoring divider (one quotient
// bit per cycle). Both feed a first-word-fall-through result FIFO.
// Optional feature macro ALU_STREAM_STATS_EN adds saturating op/err counters.
module alu_stream #(
    parameter int DATA_W     = 4,
    parameter int MUL_CYCLES = 3,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W:0]   out_result,
    output logic                out_err,
    output logic                busy
`ifdef ALU_STREAM_STATS_EN
    ,
    output logic [15:0]         op_count,
    output logic [15:0]         err_count
`endif
);

    localparam int RES_W = 2 * DATA_W + 1;
    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int CW    = $clog2(MUL_CYCLES + DATA_W + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DATA_W - 1);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    // Zero-extend an operand to the result width.
    function automatic logic [RES_W-1:0] zext(input logic [DATA_W-1:0] x);
        return {{(DATA_W + 1){1'b0}}, x};
    endfunction

    // One restoring-division iteration: returns {remainder, shifted quotient}.
    // The remainder always stays below the divisor, so DATA_W bits suffice.
    function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                      input logic [DATA_W-1:0] quo,
                                                      input logic [DATA_W-1:0] dvs);
        logic [DATA_W:0]   sh;
        logic [DATA_W-1:0] q;
        sh = {rem, quo[DATA_W-1]};
        q  = quo << 1;
        if (sh >= {1'b0, dvs}) begin
            sh   = sh - {1'b0, dvs};
            q[0] = 1'b1;
        end
        return {sh[DATA_W-1:0], q};
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [2*DATA_W-1:0] step;
    logic [AW:0]         wptr_q, rptr_q;
    logic [RES_W:0]      mem_q [OUT_DEPTH];
    logic [RES_W:0]      head;
    logic                full, accept, pop, push, push_err;
    logic [RES_W-1:0]    push_res;

    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign out_valid  = (wptr_q != rptr_q);
    assign pop        = out_valid && out_ready;
    assign in_ready   = reset_n && (state_q == S_IDLE) && !full;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != S_IDLE);
    assign head       = mem_q[rptr_q[AW-1:0]];
    assign out_result = out_valid ? head[RES_W-1:0] : '0;
    assign out_err    = out_valid & head[RES_W];

    // Divider iteration: the first bit is resolved at the accept edge from the ports.
    always_comb begin
        if (state_q == S_IDLE) step = div_step('0, in_a, in_b);
        else                   step = div_step(rem_q, quo_q, opb_q);
    end

    // Next-state, operand capture and FIFO push generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        push     = 1'b0;
        push_err = 1'b0;
        push_res = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (in_op)
                        2'd0: begin
                            push     = 1'b1;
                            push_res = zext(in_a) + zext(in_b);
                        end
                        2'd1: begin
                            push     = 1'b1;
                            push_res = zext(in_a) - zext(in_b);
                        end
                        2'd2: begin
                            if (MUL_CYCLES == 1) begin
                                push     = 1'b1;
                                push_res = zext(in_a) * zext(in_b);
                            end else begin
                                state_d = S_MUL;
                                cnt_d   = CNT_ONE;
                                opa_d   = in_a;
                                opb_d   = in_b;
                            end
                        end
                        default: begin
                            if (in_b == '0) begin
                                push     = 1'b1;
                                push_err = 1'b1;
                                push_res = '1;
                            end else if (DATA_W == 1) begin
                                push     = 1'b1;
                                push_res = zext(step[DATA_W-1:0]);
                            end else begin
                                state_d = S_DIV;
                                cnt_d   = CNT_ONE;
                                opb_d   = in_b;
                                rem_d   = step[2*DATA_W-1:DATA_W];
                                quo_d   = step[DATA_W-1:0];
                            end
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    push     = 1'b1;
                    push_res = zext(opa_q) * zext(opb_q);
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DIV: begin
                rem_d = step[2*DATA_W-1:DATA_W];
                quo_d = step[DATA_W-1:0];
                if (cnt_q == DIV_LAST) begin
                    push     = 1'b1;
                    push_res = zext(step[DATA_W-1:0]);
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, iteration counter and FIFO pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Datapath state: operands, divider registers and FIFO storage (no reset needed).
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
        if (push) mem_q[wptr_q[AW-1:0]] <= {push_err, push_res};
    end

`ifdef ALU_STREAM_STATS_EN
    // Saturating counters of pushed results and of pushed divide-by-zero results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (push) begin
            if (op_count != 16'hFFFF)              op_count  <= op_count + 16'd1;
            if (push_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
